// File: rtl/fa_result_display_pkg.sv
// Shared display constants and helpers for the adder result display.
// Holds the active-low 7-segment glyph set, digit count, mode encoding,
// and the combinational binary-to-decimal split used by the digit mux.
`timescale 1ns/1ps
package fa_result_display_pkg;

  localparam int NUM_DIGITS = 3;

  // Active-low glyphs, bit0=a .. bit6=g, bit7=dp (kept high = dp off)
  localparam logic [7:0] GLYPH_0     = 8'hC0;
  localparam logic [7:0] GLYPH_1     = 8'hF9;
  localparam logic [7:0] GLYPH_2     = 8'hA4;
  localparam logic [7:0] GLYPH_3     = 8'hB0;
  localparam logic [7:0] GLYPH_4     = 8'h99;
  localparam logic [7:0] GLYPH_5     = 8'h92;
  localparam logic [7:0] GLYPH_6     = 8'h82;
  localparam logic [7:0] GLYPH_7     = 8'hF8;
  localparam logic [7:0] GLYPH_8     = 8'h80;
  localparam logic [7:0] GLYPH_9     = 8'h90;
  localparam logic [7:0] GLYPH_A     = 8'h88;
  localparam logic [7:0] GLYPH_B     = 8'h83;
  localparam logic [7:0] GLYPH_C     = 8'hC6;
  localparam logic [7:0] GLYPH_DD    = 8'hA1;
  localparam logic [7:0] GLYPH_E     = 8'h86;
  localparam logic [7:0] GLYPH_F     = 8'h8E;
  localparam logic [7:0] GLYPH_H     = 8'h8B;
  localparam logic [7:0] GLYPH_D     = 8'hA1;
  localparam logic [7:0] GLYPH_BLANK = 8'hFF;

  typedef enum logic {
    MODE_HEX = 1'b0,
    MODE_DEC = 1'b1
  } disp_mode_e;

  typedef struct packed {
    logic [1:0] tens;
    logic [3:0] ones;
  } dec_t;

  function automatic logic [7:0] hex_glyph(input logic [3:0] v);
    logic [7:0] g;
    case (v)
      4'h0: g = GLYPH_0;
      4'h1: g = GLYPH_1;
      4'h2: g = GLYPH_2;
      4'h3: g = GLYPH_3;
      4'h4: g = GLYPH_4;
      4'h5: g = GLYPH_5;
      4'h6: g = GLYPH_6;
      4'h7: g = GLYPH_7;
      4'h8: g = GLYPH_8;
      4'h9: g = GLYPH_9;
      4'hA: g = GLYPH_A;
      4'hB: g = GLYPH_B;
      4'hC: g = GLYPH_C;
      4'hD: g = GLYPH_DD;
      4'hE: g = GLYPH_E;
      default: g = GLYPH_F;
    endcase
    return g;
  endfunction

  // 5-bit value (0..31) split into tens/ones by a compare-and-subtract chain
  function automatic dec_t bin_to_dec(input logic [4:0] v);
    dec_t d;
    logic [4:0] rem;
    if (v >= 5'd30) begin
      d.tens = 2'd3;
      rem    = v - 5'd30;
    end else if (v >= 5'd20) begin
      d.tens = 2'd2;
      rem    = v - 5'd20;
    end else if (v >= 5'd10) begin
      d.tens = 2'd1;
      rem    = v - 5'd10;
    end else begin
      d.tens = 2'd0;
      rem    = v;
    end
    d.ones = rem[3:0];
    return d;
  endfunction

endpackage

// File: rtl/fa_result_display_btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stability counter, press pulse.
// Latency: press pulse DEBOUNCE_CYCLES+2 cycles after a clean raw press.
// No backpressure; release is filtered identically but emits no pulse.
`timescale 1ns/1ps
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic [CNT_W-1:0] r_cnt;
  logic             r_press;

  // Synchronise the raw button; reset to released so a held button is re-debounced
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= btn_n;
      r_sync2 <= r_sync1;
    end
  end

  // Accept a level change after it has differed from the stable state long enough
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stable <= 1'b1;
      r_cnt    <= '0;
      r_press  <= 1'b0;
    end else begin
      r_press <= 1'b0;
      if (r_sync2 != r_stable) begin
        if (r_cnt == CNT_MAX) begin
          r_stable <= r_sync2;
          r_cnt    <= '0;
          r_press  <= ~r_sync2;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign press = r_press;

endmodule

// File: rtl/fa_result_display.sv
// Captures the adder result on a debounced press, shows it on LEDs and a 3-digit 7-seg.
// Latency: led updates DEBOUNCE_CYCLES+3 cycles after press; seg/an 1 cycle after state.
// No backpressure; display free-runs, one digit lit per REFRESH_DIV cycles.
`timescale 1ns/1ps
module fa_result_display
  import fa_result_display_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REFRESH_DIV     = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] s,
  input  logic       cout,
  input  logic       load_n,
  input  logic       mode_n,
  output logic [4:0] led,
  output logic [7:0] seg_n,
  output logic [2:0] an_n
);

  localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [REF_W-1:0] REF_MAX = REF_W'(REFRESH_DIV - 1);
  localparam logic [1:0]       DIG_MAX = 2'(NUM_DIGITS - 1);

  logic [4:0]       r_dat_sync1;
  logic [4:0]       r_dat_sync2;
  logic [4:0]       r_result;
  disp_mode_e       r_mode;
  logic [REF_W-1:0] r_ref_cnt;
  logic [1:0]       r_dig;
  logic [7:0]       r_seg_n;
  logic [2:0]       r_an_n;

  logic             w_load_press;
  logic             w_mode_press;
  dec_t             w_dec;
  logic [3:0]       w_d1_val;
  logic [7:0]       w_seg_nxt;
  logic [2:0]       w_an_nxt;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load_db (
    .clk   (clk),
    .rst   (rst),
    .btn_n (load_n),
    .press (w_load_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_db (
    .clk   (clk),
    .rst   (rst),
    .btn_n (mode_n),
    .press (w_mode_press)
  );

  // Synchronise the quasi-static adder result before it is captured
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dat_sync1 <= '0;
      r_dat_sync2 <= '0;
    end else begin
      r_dat_sync1 <= {cout, s};
      r_dat_sync2 <= r_dat_sync1;
    end
  end

  // Capture result and toggle mode; both presses may land in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_result <= '0;
      r_mode   <= MODE_HEX;
    end else begin
      if (w_load_press) begin
        r_result <= r_dat_sync2;
      end
      if (w_mode_press) begin
        r_mode <= (r_mode == MODE_HEX) ? MODE_DEC : MODE_HEX;
      end
    end
  end

  // Refresh timer: each digit is lit for REFRESH_DIV cycles, index wraps 0->1->2->0
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ref_cnt <= '0;
      r_dig     <= 2'd0;
    end else if (r_ref_cnt == REF_MAX) begin
      r_ref_cnt <= '0;
      r_dig     <= (r_dig == DIG_MAX) ? 2'd0 : r_dig + 2'd1;
    end else begin
      r_ref_cnt <= r_ref_cnt + 1'b1;
    end
  end

  assign w_dec    = bin_to_dec(r_result);
  assign w_d1_val = (r_mode == MODE_HEX) ? {3'b000, r_result[4]} : {2'b00, w_dec.tens};

  // Select the glyph and digit enable for the currently scanned digit
  always_comb begin
    w_seg_nxt = GLYPH_BLANK;
    w_an_nxt  = 3'b111;
    case (r_dig)
      2'd0: begin
        w_an_nxt  = 3'b110;
        w_seg_nxt = (r_mode == MODE_HEX) ? hex_glyph(r_result[3:0]) : hex_glyph(w_dec.ones);
      end
      2'd1: begin
        w_an_nxt  = 3'b101;
        w_seg_nxt = (w_d1_val == 4'd0) ? GLYPH_BLANK : hex_glyph(w_d1_val);
      end
      2'd2: begin
        w_an_nxt  = 3'b011;
        w_seg_nxt = (r_mode == MODE_HEX) ? GLYPH_H : GLYPH_D;
      end
      default: begin
        w_seg_nxt = GLYPH_BLANK;
        w_an_nxt  = 3'b111;
      end
    endcase
  end

  // Register the display drive so segments and enables switch together, glitch-free
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg_n <= GLYPH_BLANK;
      r_an_n  <= 3'b111;
    end else begin
      r_seg_n <= w_seg_nxt;
      r_an_n  <= w_an_nxt;
    end
  end

  assign led   = r_result;
  assign seg_n = r_seg_n;
  assign an_n  = r_an_n;

endmodule
